data_sram_bridge: RTL and testbench

- Sits directly downstream of the MEM stage.
- Converts MEM's single-cycle RAM control (ram_en / ram_write_en / ram_addr / ram_write_data / ram_size) into a split address/data "SRAM-like" handshake bus.
- Stalls the pipeline until each access completes, and returns the full read word for WB-stage alignment and extension.
- Handles exception flushes, including draining transactions the slave has already accepted.

---
 rtl/data_sram_bridge_pkg.sv | 19 +
 rtl/data_sram_bridge_if.sv | 23 ++
 rtl/data_sram_bridge.sv | 81 ++++++++
 tb/tb_data_sram_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_bridge_pkg.sv
// data_sram_bridge_pkg: state encodings and size codes shared by the data SRAM bridge
package data_sram_bridge_pkg;
  typedef enum logic [2:0] {
    DBR_STATE_IDLE  = 3'd0,
    DBR_STATE_ADDR  = 3'd1,
    DBR_STATE_DATA  = 3'd2,
    DBR_STATE_DONE  = 3'd3,
    DBR_STATE_DRAIN = 3'd4
  } dbr_state_e;
  localparam logic [1:0] BUS_SIZE_BYTE = 2'd0;
  localparam logic [1:0] BUS_SIZE_HALF = 2'd1;
  localparam logic [1:0] BUS_SIZE_WORD = 2'd2;
  localparam logic [2:0] RAM_SIZE_BYTE = 3'b000;
  localparam logic [2:0] RAM_SIZE_HALF = 3'b001;
  localparam logic [2:0] RAM_SIZE_WORD = 3'b010;
  function automatic logic [1:0] bus_size(input logic [2:0] s);
    return s == RAM_SIZE_BYTE ? BUS_SIZE_BYTE : s == RAM_SIZE_HALF ? BUS_SIZE_HALF : BUS_SIZE_WORD;
  endfunction
endpackage

// File: rtl/data_sram_bridge_if.sv
// data_sram_bridge_if: split address/data SRAM-like bus with master and slave views
interface data_sram_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );
  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: MEM RAM control to SRAM-like bus with stall and flush drain; DBRIDGE_PERF_CNT_EN adds perf counters
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en,
  input  logic [3:0]        ram_write_en,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_write_data,
  input  logic [2:0]        ram_size,
  input  logic              flush,
  output logic [DATA_W-1:0] ram_read_data,
  output logic              stall_req,
  data_sram_bridge_if.master bus
`ifdef DBRIDGE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_access_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  dbr_state_e state;
  assign stall_req = (state == DBR_STATE_ADDR) || (state == DBR_STATE_DATA) ||
                     (state == DBR_STATE_IDLE && ram_en && !flush) ||
                     (state == DBR_STATE_DRAIN && ram_en);
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= DBR_STATE_IDLE;
      bus.data_req   <= 1'b0;
      bus.data_wr    <= 1'b0;
      bus.data_size  <= 2'd0;
      bus.data_addr  <= '0;
      bus.data_wdata <= '0;
      bus.data_wstrb <= 4'd0;
      ram_read_data  <= '0;
    end else begin
      case (state)
        DBR_STATE_IDLE: if (ram_en && !flush) begin
          state          <= DBR_STATE_ADDR;
          bus.data_req   <= 1'b1;
          bus.data_wr    <= |ram_write_en;
          bus.data_size  <= bus_size(ram_size);
          bus.data_addr  <= ram_addr;
          bus.data_wdata <= ram_write_data;
          bus.data_wstrb <= ram_write_en;
        end
        DBR_STATE_ADDR: if (bus.data_addr_ok) begin
          state        <= flush ? DBR_STATE_DRAIN : DBR_STATE_DATA;
          bus.data_req <= 1'b0;
        end else if (flush) begin
          state        <= DBR_STATE_IDLE;
          bus.data_req <= 1'b0;
        end
        // a flush that coincides with data_ok simply drops the returned word
        DBR_STATE_DATA: if (bus.data_data_ok) begin
          state <= flush ? DBR_STATE_IDLE : DBR_STATE_DONE;
          if (!flush && !bus.data_wr) ram_read_data <= bus.data_rdata;
        end else if (flush) begin
          state <= DBR_STATE_DRAIN;
        end
        DBR_STATE_DONE:  state <= DBR_STATE_IDLE;
        DBR_STATE_DRAIN: if (bus.data_data_ok) state <= DBR_STATE_IDLE;
        default:         state <= DBR_STATE_IDLE;
      endcase
    end
  end
`ifdef DBRIDGE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_access_cnt <= 32'd0;
      perf_stall_cnt  <= 32'd0;
    end else begin
      if (state == DBR_STATE_ADDR && bus.data_addr_ok) perf_access_cnt <= perf_access_cnt + 32'd1;
      if (stall_req) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_data_sram_bridge.sv
// tb_data_sram_bridge: randomized scoreboard bench with a behavioural SRAM slave for data_sram_bridge
module tb_data_sram_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  ram_write_en = 4'd0;
  logic [31:0] ram_addr = 32'd0;
  logic [31:0] ram_write_data = 32'd0;
  logic [2:0]  ram_size = 3'd0;
  logic [31:0] ram_read_data;
  logic        stall_req;
`ifdef DBRIDGE_PERF_CNT_EN
  logic [31:0] perf_access_cnt, perf_stall_cnt;
  int m_acc = 0, m_stall = 0;
`endif
  data_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_size(ram_size), .flush(flush),
    .ram_read_data(ram_read_data), .stall_req(stall_req), .bus(bus)
`ifdef DBRIDGE_PERF_CNT_EN
    , .perf_access_cnt(perf_access_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wr;
    logic [1:0]  size;
  } req_t;
  req_t exp_q[$];
  int checks = 0, fails = 0;
  int a_lo = 0, a_hi = 0, d_lo = 1, d_hi = 1;
  bit use_fixed = 1'b0;
  logic [31:0] fixed_rd = 32'd0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       input logic [2:0] sz, input bit push);
    ram_en = 1'b1; ram_addr = a; ram_write_data = wd; ram_write_en = st; ram_size = sz;
    if (push) exp_q.push_back('{addr: a, wdata: wd, wstrb: st, wr: st != 4'd0,
                               size: sz == 3'b000 ? 2'd0 : sz == 3'b001 ? 2'd1 : 2'd2});
    #1 check("issue_stall", stall_req, 1);
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    do begin tick(); n++; end while (stall_req && n < 100);
    check({name, "_stall_drop"}, stall_req, 0);
  endtask

  task automatic check_zero(input string name);
    check(name, {stall_req, bus.data_req, bus.data_wr, bus.data_size, bus.data_addr,
                 bus.data_wdata, bus.data_wstrb, ram_read_data}, 0);
`ifdef DBRIDGE_PERF_CNT_EN
    check({name, "_perf"}, {perf_access_cnt, perf_stall_cnt}, 0);
`endif
  endtask

  // behavioural slave: random addr_ok wait, data_ok at least one cycle after its addr_ok
  initial begin
    bit aw, pend, r;
    int acnt, dcnt;
    aw = 0; pend = 0; acnt = 0; dcnt = 0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        aw = 0; pend = 0; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        continue;
      end
      if (bus.data_addr_ok) begin pend = 1; dcnt = $urandom_range(d_hi, d_lo); end
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      if (pend) begin
        if (dcnt == 0) begin
          bus.data_data_ok = 1'b1;
          bus.data_rdata = use_fixed ? fixed_rd : $urandom;
          pend = 0;
        end else dcnt--;
      end else if (bus.data_req) begin
        if (!aw) begin aw = 1; acnt = $urandom_range(a_hi, a_lo); end
        if (acnt == 0) begin bus.data_addr_ok = 1'b1; aw = 0; end else acnt--;
      end else aw = 0;
    end
  end

  // monitor: transaction-level model of handshake, flush and completion rules
  initial begin
    req_t r, cur, prev_f;
    bit in_data, drain, exp_done, cur_load, prev_wait;
    logic [31:0] model_rd;
    in_data = 0; drain = 0; exp_done = 0; cur_load = 0; prev_wait = 0; model_rd = 0;
    prev_f = '0;
    forever begin
      @(negedge clk);
`ifdef DBRIDGE_PERF_CNT_EN
      if (rst) begin m_acc = 0; m_stall = 0; end
      else begin
        if (bus.data_req && bus.data_addr_ok) m_acc++;
        if (stall_req) m_stall++;
      end
`endif
      if (rst) begin
        in_data = 0; drain = 0; exp_done = 0; prev_wait = 0; model_rd = 0;
        continue;
      end
      if (exp_done) begin
        check("done_stall", stall_req, 0);
        check("read_data", ram_read_data, model_rd);
        exp_done = 0;
      end
      cur = '{addr: bus.data_addr, wdata: bus.data_wdata, wstrb: bus.data_wstrb,
              wr: bus.data_wr, size: bus.data_size};
      if (prev_wait) check("req_hold", {bus.data_req, cur}, {1'b1, prev_f});
      if (bus.data_req) check("req_stall", stall_req, 1);
      if (bus.data_req && bus.data_addr_ok) begin
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_req: got handshake %0h expected none at %0t", cur, $time);
        end else begin
          r = exp_q.pop_front();
          check("bus_req", cur, r);
          cur_load = !r.wr;
        end
        in_data = 1;
        drain = flush;
      end else if (in_data && bus.data_data_ok) begin
        in_data = 0;
        if (!drain && !flush) begin
          exp_done = 1;
          if (cur_load) model_rd = bus.data_rdata;
        end
      end else if (in_data) begin
        if (drain) check("drain_stall", {stall_req, bus.data_req}, {ram_en, 1'b0});
        else if (flush) drain = 1;
        else check("data_stall", {stall_req, bus.data_req}, 2'b10);
      end
      prev_wait = bus.data_req && !bus.data_addr_ok && !flush;
      prev_f = cur;
    end
  end

  initial begin
    int n;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    // load word with fixed slave timing
    use_fixed = 1'b1; fixed_rd = 32'hDEAD_BEEF;
    drive(32'h8000_0010, 32'h1234_5678, 4'b0000, 3'b010, 1);
    wait_done("load_word", n);
    check("load_word_cycles", n, 4);
    check("load_word_rd", ram_read_data, 32'hDEAD_BEEF);
    use_fixed = 1'b0;
    tick(); ram_en = 1'b0;
    // store byte leaves the read word alone
    drive(32'h8000_0022, 32'h00AB_0000, 4'b0100, 3'b000, 1);
    wait_done("store_byte", n);
    check("store_byte_cycles", n, 4);
    check("store_byte_rd", ram_read_data, 32'hDEAD_BEEF);
    tick(); ram_en = 1'b0;
    // addr_ok withheld for five cycles
    a_lo = 5; a_hi = 5; d_lo = 0; d_hi = 0;
    drive(32'h0000_1000, 32'h0, 4'b0000, 3'b001, 1);
    wait_done("addr_wait", n);
    check("addr_wait_cycles", n, 8);
    tick(); ram_en = 1'b0;
    // randomized traffic
    a_lo = 0; a_hi = 5; d_lo = 0; d_hi = 3;
    for (int i = 0; i < 60; i++) begin
      bit st;
      st = 1'($urandom_range(1, 0));
      drive($urandom, $urandom, st ? 4'($urandom_range(15, 1)) : 4'd0, 3'($urandom_range(7, 0)), 1);
      wait_done("rand", n);
      tick(); ram_en = 1'b0;
      repeat ($urandom_range(2, 0)) tick();
    end
    // flush together with ram_en in IDLE issues nothing
    ram_en = 1'b1; flush = 1'b1; ram_write_en = 4'd0;
    #1 check("idle_flush_stall", stall_req, 0);
    tick(); ram_en = 1'b0; flush = 1'b0;
    check("idle_flush_req", bus.data_req, 0);
    // flush in ADDR before addr_ok
    a_lo = 20; a_hi = 20;
    drive($urandom, $urandom, 4'b0011, 3'b001, 0);
    tick();
    check("flush_addr_req_before", bus.data_req, 1);
    flush = 1'b1; ram_en = 1'b0;
    tick(); flush = 1'b0;
    check("flush_addr_idle", {bus.data_req, stall_req}, 0);
    repeat (3) tick();
    // flush in DATA, then a new store while the old data is drained
    a_lo = 0; a_hi = 0; d_lo = 6; d_hi = 6;
    drive($urandom, $urandom, 4'b0000, 3'b010, 1);
    tick(); tick();
    flush = 1'b1; ram_en = 1'b0;
    tick(); flush = 1'b0;
    check("drain_req_low", bus.data_req, 0);
    drive($urandom, $urandom, 4'b1111, 3'b010, 1);
    wait_done("flush_data", n);
    tick(); ram_en = 1'b0;
    // reset in DATA
    drive($urandom, $urandom, 4'b0000, 3'b010, 1);
    tick(); tick();
    rst = 1'b1; ram_en = 1'b0;
    tick();
    check_zero("reset_in_data");
    rst = 1'b0;
    a_lo = 0; a_hi = 3; d_lo = 0; d_hi = 2;
    for (int i = 0; i < 5; i++) begin
      drive($urandom, $urandom, 4'($urandom_range(1, 0) * 4'hF), 3'($urandom_range(7, 0)), 1);
      wait_done("post_reset", n);
      tick(); ram_en = 1'b0;
    end
    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
`ifdef DBRIDGE_PERF_CNT_EN
    check("perf_access", perf_access_cnt, m_acc);
    check("perf_stall", perf_stall_cnt, m_stall);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
